pl_run_ctrl: RTL and testbench

- Run/halt/step sequencer for the pipelined MIPS CPU. Sits between a host/debug command port and the CPU's global pipeline enable.
- Gates pipeline advance with cpu_en, stops on a PC breakpoint or a cycle budget, and single-steps one pipeline cycle on request.
- Gives benches and the board debug path a deterministic stop point in place of PC polling inside a testbench.

---
 rtl/pl_run_ctrl.sv | 142 ++++++++++++++
 tb/tb_pl_run_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_run_ctrl.sv
// rtl/pl_run_ctrl.sv - run/halt/step sequencer gating the CPU pipeline enable
// Breakpoint and cycle-budget stops, single-step, and saturating cycle/retire counters.
module pl_run_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int CYC_W   = 16,
  parameter int MAX_CYC = 1000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_arg,
  input  logic [ADDR_W-1:0] pc_if,
  input  logic              retire_valid,
  output logic              cpu_en,
  output logic              halted,
  output logic              bp_hit,
  output logic              timeout,
  output logic [CYC_W-1:0]  cyc_count,
  output logic [CYC_W-1:0]  ret_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_HALT  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_SETBP = 2'b11;

  localparam logic [CYC_W:0]   MAX_V   = (CYC_W+1)'(MAX_CYC);
  localparam logic [CYC_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic               bp_en;
  logic [ADDR_W-1:0]  bp_addr;
  logic               skip;

  logic               accept;
  logic               bp_match;
  logic               bp_stop;
  logic               budget_hit;
  logic               load_bp;
  logic               run_start;
  logic               clr_cnt;
  logic               set_bp_hit;
  logic               set_timeout;
  logic               unused_arg;

  assign unused_arg = cmd_arg[1];

  assign cmd_ready  = (state_q != S_STEP);
  assign accept     = cmd_valid && cmd_ready;
  assign bp_match   = bp_en && (pc_if == bp_addr);
  assign bp_stop    = bp_match && !skip;
  assign budget_hit = (MAX_CYC != 0) && ({1'b0, cyc_count} >= MAX_V);
  assign load_bp    = accept && (cmd_op == OP_SETBP);

  // A step always advances one cycle unless the budget is already exhausted.
  assign cpu_en = ((state_q == S_RUN) && !bp_stop && !budget_hit) ||
                  ((state_q == S_STEP) && !budget_hit);

  always_comb begin
    state_d     = state_q;
    run_start   = 1'b0;
    clr_cnt     = 1'b0;
    set_bp_hit  = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (accept && cmd_op == OP_RUN) begin
          state_d   = S_RUN;
          run_start = 1'b1;
          clr_cnt   = (state_q == S_IDLE);
        end else if (accept && cmd_op == OP_STEP) begin
          state_d = S_STEP;
        end
      end
      S_STEP: state_d = S_HALTED;
      S_RUN: begin
        // HALT beats the budget, which beats the breakpoint.
        if (accept && cmd_op == OP_HALT) begin
          state_d = S_HALTED;
        end else if (budget_hit) begin
          state_d     = S_HALTED;
          set_timeout = 1'b1;
        end else if (bp_stop) begin
          state_d    = S_HALTED;
          set_bp_hit = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      halted    <= 1'b1;
      bp_hit    <= 1'b0;
      timeout   <= 1'b0;
      cyc_count <= '0;
      ret_count <= '0;
      bp_en     <= 1'b0;
      bp_addr   <= '0;
      skip      <= 1'b0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == S_IDLE) || (state_d == S_HALTED);

      if (load_bp) begin
        bp_addr <= {cmd_arg[ADDR_W-1:2], 2'b00};
        bp_en   <= cmd_arg[0];
      end

      // skip lets a resume fetch the very PC it stopped on.
      if (run_start) begin
        bp_hit  <= 1'b0;
        timeout <= 1'b0;
        skip    <= 1'b1;
      end else begin
        if (state_q == S_RUN && cpu_en) skip <= 1'b0;
        if (set_bp_hit) bp_hit <= 1'b1;
        if (set_timeout) timeout <= 1'b1;
      end

      if (clr_cnt) begin
        cyc_count <= '0;
        ret_count <= '0;
      end else begin
        if (cpu_en && cyc_count != CNT_MAX) cyc_count <= cyc_count + 1'b1;
        if (cpu_en && retire_valid && ret_count != CNT_MAX) ret_count <= ret_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pl_run_ctrl.sv
// tb/tb_pl_run_ctrl.sv - directed test-plan scenarios plus randomized run against a reference model
module tb_pl_run_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;

  typedef struct {
    int          mode;
    bit          bp_en;
    logic [31:0] bp_addr;
    bit          skip;
    bit          bp_hit;
    bit          timeout;
    int          cyc;
    int          ret;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_arg = '0;
  logic [31:0] pc_if = '0;
  logic        retire_valid = 1'b0;

  logic        cmd_ready, cpu_en, halted, bp_hit, timeout;
  logic [15:0] cyc_count, ret_count;
  logic        s_cmd_ready, s_cpu_en, s_halted, s_bp_hit, s_timeout;
  logic [3:0]  s_cyc_count, s_ret_count;

  int checks = 0;
  int errors = 0;
  mdl_t m_a, m_b;

  always #5 clk = ~clk;

  pl_run_ctrl #(.ADDR_W(32), .CYC_W(16), .MAX_CYC(1000)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc_if(pc_if), .retire_valid(retire_valid),
    .cpu_en(cpu_en), .halted(halted), .bp_hit(bp_hit), .timeout(timeout),
    .cyc_count(cyc_count), .ret_count(ret_count)
  );

  // Small counters with no budget, so saturation is reached quickly.
  pl_run_ctrl #(.ADDR_W(32), .CYC_W(4), .MAX_CYC(0)) dut_s (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc_if(pc_if), .retire_valid(retire_valid),
    .cpu_en(s_cpu_en), .halted(s_halted), .bp_hit(s_bp_hit), .timeout(s_timeout),
    .cyc_count(s_cyc_count), .ret_count(s_ret_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic mdl_t m_reset();
    mdl_t r;
    r.mode = M_IDLE; r.bp_en = 0; r.bp_addr = '0; r.skip = 0;
    r.bp_hit = 0; r.timeout = 0; r.cyc = 0; r.ret = 0;
    return r;
  endfunction

  function automatic bit m_cpu_en(input mdl_t m, input int maxc, input logic [31:0] pc);
    bit over = (maxc != 0) && (m.cyc >= maxc);
    bit stop = m.bp_en && (pc == m.bp_addr) && !m.skip;
    if (m.mode == M_RUN) return !stop && !over;
    if (m.mode == M_STEP) return !over;
    return 1'b0;
  endfunction

  function automatic mdl_t m_next(input mdl_t m, input int maxc, input int sat, input bit v,
                                  input logic [1:0] op, input logic [31:0] arg,
                                  input logic [31:0] pc, input bit rv);
    mdl_t n = m;
    bit en   = m_cpu_en(m, maxc, pc);
    bit over = (maxc != 0) && (m.cyc >= maxc);
    bit stop = m.bp_en && (pc == m.bp_addr) && !m.skip;
    bit acc  = v && (m.mode != M_STEP);
    if (en) begin
      n.cyc = (m.cyc < sat) ? m.cyc + 1 : sat;
      if (rv) n.ret = (m.ret < sat) ? m.ret + 1 : sat;
      if (m.mode == M_RUN) n.skip = 0;
    end
    if (acc && op == 2'b11) begin
      n.bp_addr = arg & 32'hFFFF_FFFC;
      n.bp_en   = arg[0];
    end
    if (m.mode == M_IDLE || m.mode == M_HALT) begin
      if (acc && op == 2'b00) begin
        if (m.mode == M_IDLE) begin n.cyc = 0; n.ret = 0; end
        n.bp_hit = 0; n.timeout = 0; n.skip = 1; n.mode = M_RUN;
      end else if (acc && op == 2'b10) begin
        n.mode = M_STEP;
      end
    end else if (m.mode == M_STEP) begin
      n.mode = M_HALT;
    end else begin
      if (acc && op == 2'b01) n.mode = M_HALT;
      else if (over) begin n.mode = M_HALT; n.timeout = 1; end
      else if (stop) begin n.mode = M_HALT; n.bp_hit = 1; end
    end
    return n;
  endfunction

  task automatic compare_all();
    check("a_ready",   32'(cmd_ready), 32'(m_a.mode != M_STEP));
    check("a_cpu_en",  32'(cpu_en),    32'(m_cpu_en(m_a, 1000, pc_if)));
    check("a_halted",  32'(halted),    32'(m_a.mode == M_IDLE || m_a.mode == M_HALT));
    check("a_bp_hit",  32'(bp_hit),    32'(m_a.bp_hit));
    check("a_timeout", 32'(timeout),   32'(m_a.timeout));
    check("a_cyc",     32'(cyc_count), 32'(m_a.cyc));
    check("a_ret",     32'(ret_count), 32'(m_a.ret));
    check("s_ready",   32'(s_cmd_ready), 32'(m_b.mode != M_STEP));
    check("s_cpu_en",  32'(s_cpu_en),    32'(m_cpu_en(m_b, 0, pc_if)));
    check("s_halted",  32'(s_halted),    32'(m_b.mode == M_IDLE || m_b.mode == M_HALT));
    check("s_bp_hit",  32'(s_bp_hit),    32'(m_b.bp_hit));
    check("s_cyc",     32'(s_cyc_count), 32'(m_b.cyc));
    check("s_ret",     32'(s_ret_count), 32'(m_b.ret));
  endtask

  // One clock: compare at the falling edge, advance the models at the rising edge.
  task automatic tick(output bit en_seen);
    @(negedge clk);
    en_seen = cpu_en;
    compare_all();
    @(posedge clk);
    if (rstn) begin
      m_a = m_next(m_a, 1000, 65535, cmd_valid, cmd_op, cmd_arg, pc_if, retire_valid);
      m_b = m_next(m_b, 0, 15, cmd_valid, cmd_op, cmd_arg, pc_if, retire_valid);
    end
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] arg);
    bit e;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    tick(e);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    bit e;
    rstn = 1'b0; cmd_valid = 1'b0; retire_valid = 1'b0;
    m_a = m_reset(); m_b = m_reset();
    tick(e); tick(e);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_cyc",    32'(cyc_count), 32'd0);
    rstn = 1'b1;
  endtask

  initial begin
    bit e;
    int n;

    do_reset();

    // Budget stop after exactly 1000 enabled cycles.
    pc_if = 32'h100;
    send(2'b00, '0);
    n = 0;
    for (int i = 0; i < 1200; i++) begin
      tick(e);
      if (e) n++;
      if (halted) break;
    end
    check("budget_en_cycles", 32'(n), 32'd1000);
    check("budget_timeout", 32'(timeout), 32'd1);
    check("budget_halted", 32'(halted), 32'd1);
    check("budget_cyc", 32'(cyc_count), 32'd1000);

    // Breakpoint at 0x80 after a PC sweep.
    do_reset();
    pc_if = 32'h0;
    send(2'b11, 32'h81);
    send(2'b00, '0);
    n = 0;
    for (int i = 0; i <= 32; i++) begin
      pc_if = 32'(i * 4);
      tick(e);
      if (i == 32) check("bp_en_at_80", 32'(e), 32'd0);
      else if (e) n++;
    end
    check("bp_sweep_en", 32'(n), 32'd32);
    check("bp_hit_set", 32'(bp_hit), 32'd1);
    check("bp_cyc", 32'(cyc_count), 32'd32);

    // Two single steps; commands offered during a step are not taken.
    for (int k = 0; k < 2; k++) begin
      send(2'b10, '0);
      check("step_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1; cmd_op = 2'b00;
      tick(e);
      cmd_valid = 1'b0;
      check("step_en", 32'(e), 32'd1);
    end
    check("step_cyc", 32'(cyc_count), 32'd34);
    check("step_bp_hit", 32'(bp_hit), 32'd1);

    // Resume from the breakpoint PC without re-stopping.
    send(2'b00, '0);
    check("resume_bp_clr", 32'(bp_hit), 32'd0);
    tick(e);
    check("resume_en", 32'(e), 32'd1);

    // Retires while enabled, then HALT racing the breakpoint.
    retire_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_if = 32'h84 + 32'(i * 4);
      tick(e);
    end
    retire_valid = 1'b0;
    pc_if = 32'h80;
    cmd_valid = 1'b1; cmd_op = 2'b01;
    tick(e);
    cmd_valid = 1'b0;
    check("halt_race_en", 32'(e), 32'd0);
    check("halt_race_bp", 32'(bp_hit), 32'd0);
    check("halt_race_halted", 32'(halted), 32'd1);
    check("ret_five", 32'(ret_count), 32'd5);

    // Asynchronous reset mid-run.
    do_reset();
    pc_if = 32'h200;
    send(2'b00, '0);
    repeat (500) tick(e);
    check("mid_cyc500", 32'(cyc_count), 32'd500);
    #1 rstn = 1'b0;
    #1;
    check("async_cpu_en", 32'(cpu_en), 32'd0);
    check("async_halted", 32'(halted), 32'd1);
    check("async_bp_hit", 32'(bp_hit), 32'd0);
    check("async_timeout", 32'(timeout), 32'd0);
    check("async_cyc", 32'(cyc_count), 32'd0);
    check("async_ret", 32'(ret_count), 32'd0);
    m_a = m_reset(); m_b = m_reset();
    rstn = 1'b1;
    send(2'b00, '0);
    tick(e);
    check("restart_cyc", 32'(cyc_count), 32'd1);

    // Randomized traffic against the models.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cmd_valid    = ($urandom_range(0, 5) == 0);
      cmd_op       = 2'($urandom_range(0, 3));
      cmd_arg      = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 1));
      pc_if        = 32'($urandom_range(0, 15) * 4);
      retire_valid = 1'($urandom_range(0, 1));
      tick(e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
